// File: rtl/controle_movimento_raquetes.sv
// Paddle move-command scheduler: synchronizes the four raw buttons, resolves
// conflicting presses and emits press / auto-repeat move pulses per player.
module controle_movimento_raquetes #(
    parameter int REPEAT_DELAY  = 3,
    parameter int REPEAT_PERIOD = 2,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic enable,
    input  logic btn_dir_p1,
    input  logic btn_esq_p1,
    input  logic btn_dir_p2,
    input  logic btn_esq_p2,
    output logic mov_dir_p1,
    output logic mov_esq_p1,
    output logic mov_dir_p2,
    output logic mov_esq_p2,
    output logic repetindo_p1,
    output logic repetindo_p2
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_R, CMD_L} cmd_t;

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Bit index is player number minus one.
    logic [1:0] dir_meta, esq_meta, dir_sync, esq_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes the
    // two synchronizer stages behave as two separate stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_meta <= '0;
            esq_meta <= '0;
            dir_sync <= '0;
            esq_sync <= '0;
        end else begin
            dir_meta <= {btn_dir_p2, btn_dir_p1};
            esq_meta <= {btn_esq_p2, btn_esq_p1};
            dir_sync <= dir_meta;
            esq_sync <= esq_meta;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        cmd_t             cmd;
        cmd_t             dir, dir_nxt;
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             pulse_dir_nxt, pulse_esq_nxt;
        logic             mov_dir_q, mov_esq_q, repetindo_q;

        always_comb begin
            case ({dir_sync[p], esq_sync[p]})
                2'b10:   cmd = CMD_R;
                2'b01:   cmd = CMD_L;
                default: cmd = CMD_NONE;
            endcase
        end

        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        always_comb begin
            state_nxt     = state;
            dir_nxt       = dir;
            cnt_nxt       = cnt;
            pulse_dir_nxt = 1'b0;
            pulse_esq_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (enable && cmd != CMD_NONE) begin
                        pulse_dir_nxt = (cmd == CMD_R);
                        pulse_esq_nxt = (cmd == CMD_L);
                        dir_nxt       = cmd;
                        cnt_nxt       = DELAY_LOAD;
                        state_nxt     = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    // Leaving wins over a coincident tick: no pulse on exit.
                    if (cmd != dir || !enable) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        if (cnt == CNT_ONE) begin
                            pulse_dir_nxt = (dir == CMD_R);
                            pulse_esq_nxt = (dir == CMD_L);
                            cnt_nxt       = PERIOD_LOAD;
                            state_nxt     = REPEAT;
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state        <= IDLE;
                dir          <= CMD_NONE;
                cnt          <= '0;
                mov_dir_q    <= 1'b0;
                mov_esq_q    <= 1'b0;
                repetindo_q  <= 1'b0;
            end else begin
                state        <= state_nxt;
                dir          <= dir_nxt;
                cnt          <= cnt_nxt;
                mov_dir_q    <= pulse_dir_nxt;
                mov_esq_q    <= pulse_esq_nxt;
                repetindo_q  <= (state_nxt == REPEAT);
            end
        end
    end

    assign mov_dir_p1   = g_player[0].mov_dir_q;
    assign mov_esq_p1   = g_player[0].mov_esq_q;
    assign repetindo_p1 = g_player[0].repetindo_q;
    assign mov_dir_p2   = g_player[1].mov_dir_q;
    assign mov_esq_p2   = g_player[1].mov_esq_q;
    assign repetindo_p2 = g_player[1].repetindo_q;

    // Zero delay/period would never fire; values must also fit in cnt.
    param_range_ok: assert property (@(posedge clk)
        (REPEAT_DELAY >= 1) && (REPEAT_DELAY < (1 << CNT_W)) &&
        (REPEAT_PERIOD >= 1) && (REPEAT_PERIOD < (1 << CNT_W)));

    pulses_exclusive: assert property (@(posedge clk)
        !(mov_dir_p1 && mov_esq_p1) && !(mov_dir_p2 && mov_esq_p2));

endmodule

// File: tb/tb_controle_movimento_raquetes.sv
// Table-driven bench: per-cycle stimulus/expected records, expected outputs
// queued at drive time and compared when the outputs settle after the edge.
module tb_controle_movimento_raquetes;

    localparam int MAX_N = 64;
    // Expected-output bit positions: {md1, me1, md2, me2, rep1, rep2}
    localparam int MD1 = 5, ME1 = 4, MD2 = 3, ME2 = 2, RP1 = 1, RP2 = 0;
    // Button bit positions: {bd1, be1, bd2, be2}
    localparam int BD1 = 3, BE1 = 2, BD2 = 1, BE2 = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       tck;
        logic [3:0] btn;
        logic [5:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset, tick, enable;
    logic btn_dir_p1, btn_esq_p1, btn_dir_p2, btn_esq_p2;
    logic mov_dir_p1, mov_esq_p1, mov_dir_p2, mov_esq_p2;
    logic repetindo_p1, repetindo_p2;

    vec_t       tbl [MAX_N];
    int         n;
    logic [5:0] sb [$];
    int         checks = 0;
    int         errors = 0;

    controle_movimento_raquetes #(
        .REPEAT_DELAY (3),
        .REPEAT_PERIOD(2),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .enable      (enable),
        .btn_dir_p1  (btn_dir_p1),
        .btn_esq_p1  (btn_esq_p1),
        .btn_dir_p2  (btn_dir_p2),
        .btn_esq_p2  (btn_esq_p2),
        .mov_dir_p1  (mov_dir_p1),
        .mov_esq_p1  (mov_esq_p1),
        .mov_dir_p2  (mov_dir_p2),
        .mov_esq_p2  (mov_esq_p2),
        .repetindo_p1(repetindo_p1),
        .repetindo_p2(repetindo_p2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] outs();
        return {mov_dir_p1, mov_esq_p1, mov_dir_p2, mov_esq_p2, repetindo_p1, repetindo_p2};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (md1 me1 md2 me2 rep1 rep2)", name, act, req);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic tck, input logic [3:0] btn);
        reset  = rst;
        enable = en;
        tick   = tck;
        {btn_dir_p1, btn_esq_p1, btn_dir_p2, btn_esq_p2} = btn;
    endtask

    // Default table: enable high, tick on every 4th cycle (local index 3, 7, ...).
    task automatic new_table(input int len);
        n = len;
        for (int k = 0; k < MAX_N; k++) begin
            tbl[k].rst = 1'b0;
            tbl[k].en  = 1'b1;
            tbl[k].tck = (k % 4 == 3);
            tbl[k].btn = '0;
            tbl[k].exp = '0;
        end
    endtask

    task automatic hold(input int b, input int from, input int to);
        for (int k = from; k <= to; k++) tbl[k].btn[b] = 1'b1;
    endtask

    task automatic pulse_at(input int b, input int k);
        tbl[k].exp[b] = 1'b1;
    endtask

    task automatic level(input int b, input int from, input int to);
        for (int k = from; k <= to; k++) tbl[k].exp[b] = 1'b1;
    endtask

    // Two reset cycles (outputs must be zero), then the table; entry k's
    // expectation is the output after the k-th clock edge of the table.
    task automatic run_table(input string name);
        logic [5:0] req;
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 1'b1, 1'b0, 4'b0000);
            sb.push_back(6'b000000);
            @(posedge clk);
            @(negedge clk);
            req = sb.pop_front();
            check($sformatf("%s_reset%0d", name, r), outs(), req);
        end
        for (int k = 0; k < n; k++) begin
            drive(tbl[k].rst, tbl[k].en, tbl[k].tck, tbl[k].btn);
            sb.push_back(tbl[k].exp);
            @(posedge clk);
            @(negedge clk);
            req = sb.pop_front();
            check($sformatf("%s[%0d]", name, k), outs(), req);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);

        // Hold right p1: press pulse, 3rd tick, then every 2nd tick.
        new_table(40);
        hold(BD1, 0, 39);
        pulse_at(MD1, 2);  pulse_at(MD1, 11); pulse_at(MD1, 19);
        pulse_at(MD1, 27); pulse_at(MD1, 35);
        level(RP1, 11, 39);
        run_table("hold_dir_p1");

        // Both p2 buttons pressed: nothing; releasing left gives right pulse.
        new_table(60);
        hold(BD2, 0, 59);
        hold(BE2, 0, 49);
        pulse_at(MD2, 52);
        run_table("conflict_p2");

        // Release in DELAY: one pulse; re-press lands on a tick, which is ignored.
        new_table(26);
        hold(BE1, 0, 4);
        hold(BE1, 9, 25);
        pulse_at(ME1, 2); pulse_at(ME1, 11); pulse_at(ME1, 23);
        level(RP1, 23, 25);
        run_table("release_in_delay");

        // Reversal in REPEAT: leave (also on a tick), gap, new-direction pulse.
        new_table(30);
        hold(BD1, 0, 12);
        hold(BE1, 13, 29);
        pulse_at(MD1, 2);  pulse_at(MD1, 11);
        pulse_at(ME1, 16); pulse_at(ME1, 27);
        level(RP1, 11, 14);
        level(RP1, 27, 29);
        run_table("reversal");

        // Enable dropped for 10 cycles in REPEAT, button held throughout.
        new_table(46);
        hold(BD1, 0, 45);
        for (int k = 21; k <= 30; k++) tbl[k].en = 1'b0;
        pulse_at(MD1, 2);  pulse_at(MD1, 11); pulse_at(MD1, 19);
        pulse_at(MD1, 31); pulse_at(MD1, 43);
        level(RP1, 11, 20);
        level(RP1, 43, 45);
        run_table("enable_drop");

        // Reset on a repeat-pulse cycle with both players in REPEAT.
        new_table(38);
        hold(BD1, 0, 37);
        hold(BE2, 0, 37);
        tbl[19].rst = 1'b1;
        pulse_at(MD1, 2);  pulse_at(MD1, 11); pulse_at(MD1, 22); pulse_at(MD1, 31);
        pulse_at(ME2, 2);  pulse_at(ME2, 11); pulse_at(ME2, 22); pulse_at(ME2, 31);
        level(RP1, 11, 18); level(RP1, 31, 37);
        level(RP2, 11, 18); level(RP2, 31, 37);
        run_table("reset_mid_repeat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_movimento_raquetes.md
Name: controle_movimento_raquetes

Overview:
Move-command scheduler for the two paddle position counters. It takes raw left/right button levels from both players and synchronizes them, then resolves conflicting presses. Its outputs are single-cycle move pulses: one on press, then auto-repeat pulses at a game-tick-based rate while the button is held. It sits between the board buttons and the per-player paddle position registers, whose botao_direita/botao_esquerda inputs it drives.

Parameters:
REPEAT_DELAY, 3, ticks from the press pulse to the first repeat pulse (valid range 1..255)
REPEAT_PERIOD, 2, ticks between repeat pulses (valid range 1..255)
CNT_W, 8, tick counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle game-rate strobe
enable  in  1  game running; 0 suppresses all moves
btn_dir_p1  in  1  raw right button, player 1 (asynchronous)
btn_esq_p1  in  1  raw left button, player 1 (asynchronous)
btn_dir_p2  in  1  raw right button, player 2 (asynchronous)
btn_esq_p2  in  1  raw left button, player 2 (asynchronous)
mov_dir_p1  out  1  one-cycle move-right pulse, player 1
mov_esq_p1  out  1  one-cycle move-left pulse, player 1
mov_dir_p2  out  1  one-cycle move-right pulse, player 2
mov_esq_p2  out  1  one-cycle move-left pulse, player 2
repetindo_p1  out  1  player 1 in REPEAT state
repetindo_p2  out  1  player 2 in REPEAT state

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: all outputs 0, both FSMs IDLE, both counters 0, all synchronizer flops 0.
- Input synchronization: each button passes through a 2-flop synchronizer.
- Per-player command, from synchronized levels:
  - R = dir & ~esq
  - L = esq & ~dir
  - both pressed or neither pressed gives NONE
- Per-player FSM: two identical, fully independent instances. Each holds a latched direction D and a counter cnt.
- IDLE:
  - if enable and cmd is not NONE: pulse the matching output this cycle, latch D = cmd, load cnt = REPEAT_DELAY, go to DELAY
  - otherwise stay in IDLE
- DELAY:
  - if cmd != D or enable = 0: go to IDLE, no pulse
  - else on tick with cnt == 1: pulse D, load cnt = REPEAT_PERIOD, go to REPEAT
  - else on tick: cnt decrements by 1
  - no tick: hold
- REPEAT:
  - exit conditions are the same as in DELAY
  - on tick with cnt == 1: pulse D, reload cnt = REPEAT_PERIOD
  - else on tick: cnt decrements by 1
- Latency: from a raw button edge to the first pulse is 3 rising clk edges (2 synchronizer stages plus the registered FSM output). The first pulse does not wait for tick.
- Pulse outputs:
  - registered
  - exactly 1 cycle wide
  - mov_dir_pN and mov_esq_pN are never high in the same cycle
- Direction reversal while held: the FSM returns to IDLE in the cycle the change is seen. On the next cycle IDLE issues the new-direction pulse, so there is a 1-cycle gap with no pulse.
- tick coincident with a leave condition: leaving takes priority, no pulse.
- tick in the same cycle as the IDLE press: ignored, counting starts with the next tick.
- enable deassert: any state goes to IDLE and pulses stop. On re-enable with a button still held, IDLE issues an immediate pulse.
- Paddle range limits: not checked here. The paddle position counter saturates at its own limits; this block pulses regardless.
- Reset mid-operation: on the next clk edge, all outputs and the state of both players return to reset values.
- Counter width: cnt is CNT_W bits. REPEAT_DELAY/REPEAT_PERIOD of 0 is illegal and is flagged by a simulation assertion.
- repetindo_pN: registered, high exactly while the FSM is in REPEAT.

Test Plan:
Defaults (REPEAT_DELAY=3, REPEAT_PERIOD=2), enable=1, tick every 4 clocks unless noted.
1. Hold btn_dir_p1 from cycle 0 → mov_dir_p1 pulse at cycle 3; next pulse on the 3rd following tick; then a pulse on every 2nd tick; repetindo_p1=1 from the first repeat pulse; player 2 outputs stay 0.
2. Assert btn_dir_p2 and btn_esq_p2 together for 50 cycles → no mov_*_p2 pulses, FSM stays IDLE. Then release btn_esq_p2 only → mov_dir_p2 pulse 3 cycles later.
3. Hold btn_esq_p1, release after 1 tick (still in DELAY) → exactly one mov_esq_p1 pulse total. Re-press → immediate pulse 3 cycles later, counting restarts from REPEAT_DELAY.
4. Hold btn_dir_p1 into REPEAT, then switch to btn_esq_p1 in one cycle → mov_dir_p1 stops; mov_esq_p1 pulses 1 cycle after the reversal reaches the FSM; no cycle has both pulses.
5. In REPEAT, drop enable for 10 cycles with the button held → no pulses, repetindo_p1=0. Raise enable → mov pulse on the next cycle, then the DELAY timing of scenario 1.
6. Assert reset for 1 cycle mid-REPEAT on both players → all outputs 0 on the next edge. After release with buttons held → first pulses 3 cycles later (synchronizers refill).
